config_loader: RTL

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/config_loader.sv
// Serial loader that streams host words LSB-first into a downstream config_cell chain.
// Optional readback compare of the chain tail is enabled by defining CONFIG_LOADER_READBACK_EN.
module config_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              config_clk,
    output logic              config_reset,
    output logic              config_in,
    input  logic              config_ret,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CW = $clog2(CHAIN_LEN + 1);
    localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_LOAD,
        S_SLO,
        S_SHI,
        S_FIN
    } state_t;

    state_t            r_state, w_state_nx;
    logic [CW-1:0]     r_bit_cnt, w_bit_cnt_nx, w_bit_inc;
    logic [IW-1:0]     r_idx, w_idx_nx;
    logic [WORD_W-1:0] r_shift, w_shift_nx, w_shift_sh;
    logic              r_crst_cnt, w_crst_nx;
    logic              r_config_in, w_cin_nx;
    logic              r_cfg_ready, r_config_clk, r_config_reset, r_busy, r_done;

`ifdef CONFIG_LOADER_READBACK_EN
    logic              r_verify, w_verify_nx;
    logic              r_err, w_err_nx;
`else
    logic              w_unused;
    assign w_unused = config_ret ^ verify;
`endif

    assign w_bit_inc  = r_bit_cnt + 1'b1;
    assign w_shift_sh = r_shift >> 1;

    always_comb begin
        w_state_nx   = r_state;
        w_bit_cnt_nx = r_bit_cnt;
        w_idx_nx     = r_idx;
        w_shift_nx   = r_shift;
        w_crst_nx    = r_crst_cnt;
        w_cin_nx     = r_config_in;
`ifdef CONFIG_LOADER_READBACK_EN
        w_verify_nx  = r_verify;
        w_err_nx     = r_err;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_bit_cnt_nx = '0;
                    w_crst_nx    = 1'b0;
                    w_state_nx   = verify ? S_LOAD : S_CRST;
`ifdef CONFIG_LOADER_READBACK_EN
                    w_verify_nx  = verify;
                    if (verify) w_err_nx = 1'b0;
`endif
                end
            end
            S_CRST: begin
                if (r_crst_cnt) w_state_nx = S_LOAD;
                else            w_crst_nx  = 1'b1;
            end
            S_LOAD: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_shift_nx = cfg_data;
                    w_idx_nx   = '0;
                    w_cin_nx   = cfg_data[0];
                    w_state_nx = S_SLO;
                end
            end
            S_SLO: begin
                w_state_nx = S_SHI;
`ifdef CONFIG_LOADER_READBACK_EN
                if (r_verify && (config_ret != r_config_in)) w_err_nx = 1'b1;
`endif
            end
            S_SHI: begin
                w_bit_cnt_nx = w_bit_inc;
                // Tail bits of the last word are dropped by ending the pass on the bit count.
                if (w_bit_inc == CW'(CHAIN_LEN)) begin
                    w_cin_nx   = 1'b0;
                    w_state_nx = S_FIN;
                end else if (r_idx == IW'(WORD_W - 1)) begin
                    w_state_nx = S_LOAD;
                end else begin
                    w_shift_nx = w_shift_sh;
                    w_cin_nx   = w_shift_sh[0];
                    w_idx_nx   = r_idx + 1'b1;
                    w_state_nx = S_SLO;
                end
            end
            S_FIN: begin
                w_cin_nx   = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next-state decode so they line up with r_state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_bit_cnt      <= '0;
            r_idx          <= '0;
            r_shift        <= '0;
            r_crst_cnt     <= 1'b0;
            r_config_in    <= 1'b0;
            r_cfg_ready    <= 1'b0;
            r_config_clk   <= 1'b0;
            r_config_reset <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
            r_verify       <= 1'b0;
            r_err          <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_bit_cnt      <= w_bit_cnt_nx;
            r_idx          <= w_idx_nx;
            r_shift        <= w_shift_nx;
            r_crst_cnt     <= w_crst_nx;
            r_config_in    <= w_cin_nx;
            r_cfg_ready    <= (w_state_nx == S_LOAD);
            r_config_clk   <= (w_state_nx == S_SHI);
            r_config_reset <= (w_state_nx == S_CRST);
            r_busy         <= (w_state_nx != S_IDLE);
            r_done         <= (w_state_nx == S_FIN);
`ifdef CONFIG_LOADER_READBACK_EN
            r_verify       <= w_verify_nx;
            r_err          <= w_err_nx;
`endif
        end
    end

    assign cfg_ready    = r_cfg_ready;
    assign config_clk   = r_config_clk;
    assign config_reset = r_config_reset;
    assign config_in    = r_config_in;
    assign busy         = r_busy;
    assign done         = r_done;
`ifdef CONFIG_LOADER_READBACK_EN
    assign err          = r_err;
`else
    assign err          = 1'b0;
`endif

endmodule
